// File: rtl/runway_scheduler_if.sv
// runway_scheduler_if: request, done, lock-manager and grant signals of the runway scheduler.
//   master : radio front end / lock manager / comms side (drives requests, dones, runway_active)
//   slave  : runway_scheduler
// QUEUE_DEPTH must match the scheduler instance; CW is derived from it.
interface runway_scheduler_if #(
  parameter int unsigned QUEUE_DEPTH = 8
);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_plane_id;
  logic          req_type;
  logic          req_emergency;
  logic          done_valid;
  logic [3:0]    done_plane_id;
  logic          done_runway;
  logic [1:0]    runway_active;
  logic          lock;
  logic          unlock;
  logic [3:0]    plane_id;
  logic          runway_id;
  logic          grant_valid;
  logic [3:0]    grant_plane_id;
  logic          grant_runway;
  logic          grant_type;
  logic [CW-1:0] queue_count;
  logic          done_err;

  modport master (
    output req_valid, req_plane_id, req_type, req_emergency,
    output done_valid, done_plane_id, done_runway, runway_active,
    input  req_ready, lock, unlock, plane_id, runway_id,
    input  grant_valid, grant_plane_id, grant_runway, grant_type, queue_count, done_err
  );

  modport slave (
    input  req_valid, req_plane_id, req_type, req_emergency,
    input  done_valid, done_plane_id, done_runway, runway_active,
    output req_ready, lock, unlock, plane_id, runway_id,
    output grant_valid, grant_plane_id, grant_runway, grant_type, queue_count, done_err
  );
endinterface

// File: rtl/runway_scheduler.sv
// runway_scheduler: queues landing/takeoff requests in arrival order and sequences one-cycle
// lock/unlock commands to the two-runway lock manager, confirming each lock with a grant pulse
// once the manager reports the runway active.
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   bus      runway_scheduler_if.slave: request handshake, done reports, runway_active
//            feedback, lock/unlock command, grant confirmation, queue_count, done_err
// Optional: define BOBATC_EMERGENCY_PRIORITY_EN to add a one-entry emergency holding register
// that is served ahead of the FIFO head (but after pending unlocks).
module runway_scheduler #(
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input logic               clock,
  input logic               reset_n,
  runway_scheduler_if.slave bus
);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned AW = $clog2(QUEUE_DEPTH);

  typedef struct packed {
    logic [3:0] plane;
    logic       kind;
  } entry_t;

  typedef enum logic [2:0] {StIdle, StLock, StWaitSet, StUnlock, StWaitClr} state_e;

  state_e state_q, state_d;
  entry_t cur_q, cur_d;
  logic   rw_q, rw_d;

  entry_t          fifo_q [QUEUE_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full, empty, push, push_fifo, pop_fifo, has_work;

  logic [1:0]      owned_q, pending_q, free, rw_sel, done_sel, done_hit;
  logic [1:0][3:0] owner_q;
  logic            done_ok, done_err_q;
  logic            lock, unlock, grant_d, grant_valid_q, gnt_runway_q, gnt_type_q;
  logic [3:0]      gnt_plane_q;

`ifdef BOBATC_EMERGENCY_PRIORITY_EN
  logic   em_valid_q, push_em, pop_em, src_em_q, src_em_d;
  entry_t em_q;

  // Emergency requests only contend for the holding register, not for FIFO space.
  assign bus.req_ready   = bus.req_emergency ? !em_valid_q : !full;
  assign push_em         = push && bus.req_emergency;
  assign push_fifo       = push && !bus.req_emergency;
  assign has_work        = em_valid_q || !empty;
  assign bus.queue_count = count_q + CW'(em_valid_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      em_valid_q <= 1'b0;
      em_q       <= '0;
      src_em_q   <= 1'b0;
    end else begin
      src_em_q <= src_em_d;
      if (push_em) begin
        em_valid_q <= 1'b1;
        em_q       <= {bus.req_plane_id, bus.req_type};
      end else if (pop_em) begin
        em_valid_q <= 1'b0;
      end
    end
  end
`else
  logic unused_emergency;

  assign unused_emergency = bus.req_emergency;
  assign bus.req_ready    = !full;
  assign push_fifo        = push;
  assign has_work         = !empty;
  assign bus.queue_count  = count_q;
`endif

  assign full  = (count_q == CW'(QUEUE_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.req_valid && bus.req_ready;

  always_ff @(posedge clock) begin
    if (push_fifo) fifo_q[wr_ptr_q] <= {bus.req_plane_id, bus.req_type};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_fifo) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_fifo)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_fifo && !pop_fifo)      count_q <= count_q + 1'b1;
      else if (!push_fifo && pop_fifo) count_q <= count_q - 1'b1;
    end
  end

  // A done is accepted only from the plane that currently owns the named runway.
  assign free     = ~owned_q & ~bus.runway_active;
  assign rw_sel   = rw_q ? 2'b10 : 2'b01;
  assign done_sel = bus.done_runway ? 2'b10 : 2'b01;
  assign done_ok  = bus.done_valid && owned_q[bus.done_runway] &&
                    (owner_q[bus.done_runway] == bus.done_plane_id);
  assign done_hit = done_ok ? done_sel : 2'b00;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owned_q    <= '0;
      owner_q    <= '0;
      pending_q  <= '0;
      done_err_q <= 1'b0;
    end else begin
      done_err_q <= bus.done_valid && !done_ok;
      for (int r = 0; r < 2; r++) begin
        if (lock && rw_sel[r]) begin
          owned_q[r] <= 1'b1;
          owner_q[r] <= cur_q.plane;
        end
        // Unlock wins over a same-cycle done; that done is a duplicate for the pending slot.
        if (unlock && rw_sel[r]) begin
          owned_q[r]   <= 1'b0;
          pending_q[r] <= 1'b0;
        end else if (done_hit[r]) begin
          pending_q[r] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rw_d     = rw_q;
    lock     = 1'b0;
    unlock   = 1'b0;
    pop_fifo = 1'b0;
    grant_d  = 1'b0;
`ifdef BOBATC_EMERGENCY_PRIORITY_EN
    src_em_d = src_em_q;
    pop_em   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (|pending_q) begin
          rw_d       = !pending_q[0];
          cur_d.plane = owner_q[!pending_q[0]];
          cur_d.kind  = 1'b0;
          state_d    = StUnlock;
        end else if (has_work && (|free)) begin
          rw_d = !free[0];
`ifdef BOBATC_EMERGENCY_PRIORITY_EN
          src_em_d = em_valid_q;
          cur_d    = em_valid_q ? em_q : fifo_q[rd_ptr_q];
`else
          cur_d = fifo_q[rd_ptr_q];
`endif
          state_d = StLock;
        end
      end
      StLock: begin
        lock = 1'b1;
`ifdef BOBATC_EMERGENCY_PRIORITY_EN
        pop_em   = src_em_q;
        pop_fifo = !src_em_q;
`else
        pop_fifo = 1'b1;
`endif
        state_d = StWaitSet;
      end
      StWaitSet: begin
        if (bus.runway_active[rw_q]) begin
          grant_d = 1'b1;
          state_d = StIdle;
        end
      end
      StUnlock: begin
        unlock  = 1'b1;
        state_d = StWaitClr;
      end
      StWaitClr: begin
        if (!bus.runway_active[rw_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cur_q         <= '0;
      rw_q          <= 1'b0;
      grant_valid_q <= 1'b0;
      gnt_plane_q   <= '0;
      gnt_runway_q  <= 1'b0;
      gnt_type_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      rw_q          <= rw_d;
      grant_valid_q <= grant_d;
      gnt_plane_q   <= grant_d ? cur_q.plane : 4'd0;
      gnt_runway_q  <= grant_d && rw_q;
      gnt_type_q    <= grant_d && cur_q.kind;
    end
  end

  assign bus.lock           = lock;
  assign bus.unlock         = unlock;
  assign bus.plane_id       = (lock || unlock) ? cur_q.plane : 4'd0;
  assign bus.runway_id      = (lock || unlock) && rw_q;
  assign bus.grant_valid    = grant_valid_q;
  assign bus.grant_plane_id = gnt_plane_q;
  assign bus.grant_runway   = gnt_runway_q;
  assign bus.grant_type     = gnt_type_q;
  assign bus.done_err       = done_err_q;
endmodule

// File: tb/tb_runway_scheduler.sv
// tb_runway_scheduler: directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level reference model (request queue, ownership table, one in-flight operation).
module tb_runway_scheduler;
  localparam int unsigned QUEUE_DEPTH = 8;
  localparam int PhIdle = 0, PhLock = 1, PhWaitSet = 2, PhUnlock = 3, PhWaitClr = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  runway_scheduler_if #(.QUEUE_DEPTH(QUEUE_DEPTH)) bus ();
  runway_scheduler #(.QUEUE_DEPTH(QUEUE_DEPTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the scheduler should hold after each clock edge.
  logic [4:0] m_q [$];  // {plane, type}
  logic       m_em_valid;
  logic [4:0] m_em;
  logic       m_owned [2];
  logic [3:0] m_owner [2];
  logic       m_pend [2];
  int         m_phase, m_rw;
  logic [4:0] m_cur;
  logic       m_cur_em, m_gnt, m_err;
  int         m_gnt_plane, m_gnt_rw, m_gnt_type;

  // Lock-manager stand-in: runway_active follows lock/unlock after a random delay.
  logic [1:0] mgr_tgt;
  int         mgr_cnt [2];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic emerg);
`ifdef BOBATC_EMERGENCY_PRIORITY_EN
    if (emerg) return !m_em_valid;
`endif
    return (m_q.size() < int'(QUEUE_DEPTH)) || (emerg && 1'b0);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_em_valid = 1'b0;
    m_em       = '0;
    for (int i = 0; i < 2; i++) begin
      m_owned[i] = 1'b0;
      m_owner[i] = '0;
      m_pend[i]  = 1'b0;
      mgr_cnt[i] = 0;
    end
    m_phase = PhIdle;
    m_rw = 0;
    m_cur = '0;
    m_cur_em = 1'b0;
    m_gnt = 1'b0;
    m_err = 1'b0;
    m_gnt_plane = 0;
    m_gnt_rw = 0;
    m_gnt_type = 0;
    mgr_tgt = 2'b00;
  endtask

  // Advance the model across one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic [1:0] act, free;
    logic       old_owned [2];
    logic [3:0] old_owner [2];
    logic       old_pend [2];
    logic       old_em, rdy;
    int         old_size, r;
    act = bus.runway_active;
    for (int i = 0; i < 2; i++) begin
      old_owned[i] = m_owned[i];
      old_owner[i] = m_owner[i];
      old_pend[i]  = m_pend[i];
      free[i]      = !m_owned[i] && !act[i];
    end
    old_em   = m_em_valid;
    old_size = m_q.size();
    rdy      = model_ready(bus.req_emergency);
    m_gnt = 1'b0;
    m_err = 1'b0;
    if (bus.done_valid) begin
      r = int'(bus.done_runway);
      if (old_owned[r] && old_owner[r] == bus.done_plane_id) m_pend[r] = 1'b1;
      else m_err = 1'b1;
    end
    if (bus.req_valid && rdy) begin
`ifdef BOBATC_EMERGENCY_PRIORITY_EN
      if (bus.req_emergency) begin
        m_em_valid = 1'b1;
        m_em = {bus.req_plane_id, bus.req_type};
      end else begin
        m_q.push_back({bus.req_plane_id, bus.req_type});
      end
`else
      m_q.push_back({bus.req_plane_id, bus.req_type});
`endif
    end
    case (m_phase)
      PhIdle: begin
        if (old_pend[0] || old_pend[1]) begin
          m_rw = old_pend[0] ? 0 : 1;
          m_cur = {old_owner[m_rw], 1'b0};
          m_phase = PhUnlock;
        end else if ((old_em || old_size > 0) && free != 2'b00) begin
          m_rw = free[0] ? 0 : 1;
          m_cur_em = old_em;
          m_cur = old_em ? m_em : m_q[0];
          m_phase = PhLock;
        end
      end
      PhLock: begin
        if (m_cur_em) m_em_valid = 1'b0;
        else void'(m_q.pop_front());
        m_owned[m_rw] = 1'b1;
        m_owner[m_rw] = m_cur[4:1];
        m_phase = PhWaitSet;
      end
      PhWaitSet: begin
        if (act[m_rw]) begin
          m_gnt = 1'b1;
          m_gnt_plane = int'(m_cur[4:1]);
          m_gnt_type = int'(m_cur[0]);
          m_gnt_rw = m_rw;
          m_phase = PhIdle;
        end
      end
      PhUnlock: begin
        m_owned[m_rw] = 1'b0;
        m_pend[m_rw] = 1'b0;
        m_phase = PhWaitClr;
      end
      default: begin
        if (!act[m_rw]) m_phase = PhIdle;
      end
    endcase
  endtask

  task automatic compare_outputs();
    logic lk, ul;
    lk = (m_phase == PhLock);
    ul = (m_phase == PhUnlock);
    check_eq("lock", bus.lock, lk);
    check_eq("unlock", bus.unlock, ul);
    check_eq("plane_id", bus.plane_id, (lk || ul) ? int'(m_cur[4:1]) : 0);
    check_eq("runway_id", bus.runway_id, (lk || ul) ? m_rw : 0);
    check_eq("grant_valid", bus.grant_valid, m_gnt);
    check_eq("grant_plane_id", bus.grant_plane_id, m_gnt ? m_gnt_plane : 0);
    check_eq("grant_runway", bus.grant_runway, m_gnt ? m_gnt_rw : 0);
    check_eq("grant_type", bus.grant_type, m_gnt ? m_gnt_type : 0);
    check_eq("done_err", bus.done_err, m_err);
    check_eq("queue_count", bus.queue_count, m_q.size() + int'(m_em_valid));
  endtask

  task automatic manager();
    logic [1:0] a;
    a = bus.runway_active;
    for (int i = 0; i < 2; i++) begin
      if ((bus.lock || bus.unlock) && int'(bus.runway_id) == i) begin
        mgr_tgt[i] = bus.lock;
        mgr_cnt[i] = $urandom_range(0, 2);
      end
      if (a[i] != mgr_tgt[i]) begin
        if (mgr_cnt[i] == 0) a[i] = mgr_tgt[i];
        else mgr_cnt[i]--;
      end
    end
    bus.runway_active = a;
  endtask

  task automatic tick(input logic rv, input logic [3:0] rp, input logic rt, input logic re,
                      input logic dv, input logic [3:0] dp, input logic dr);
    @(negedge clock);
    model_step();
    compare_outputs();
    manager();
    bus.req_valid     = rv;
    bus.req_plane_id  = rp;
    bus.req_type      = rt;
    bus.req_emergency = re;
    bus.done_valid    = dv;
    bus.done_plane_id = dp;
    bus.done_runway   = dr;
    #1;
    check_eq("req_ready", bus.req_ready, model_ready(re));
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic push(input logic [3:0] p, input logic t, input logic e);
    tick(1'b1, p, t, e, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic done(input logic [3:0] p, input logic r);
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, p, r);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once, without a clock edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_plane_id = '0;
    bus.req_type = 1'b0;
    bus.req_emergency = 1'b0;
    bus.done_valid = 1'b0;
    bus.done_plane_id = '0;
    bus.done_runway = 1'b0;
    bus.runway_active = 2'b00;
    #1;
    check_eq("rst_lock", bus.lock, 0);
    check_eq("rst_unlock", bus.unlock, 0);
    check_eq("rst_plane_id", bus.plane_id, 0);
    check_eq("rst_grant_valid", bus.grant_valid, 0);
    check_eq("rst_done_err", bus.done_err, 0);
    check_eq("rst_queue_count", bus.queue_count, 0);
    check_eq("rst_req_ready", bus.req_ready, 1);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic       rv, rt, re, dv, dr;
    logic [3:0] rp, dp;
    do_reset();

    // Single request: plane 3 landing on runway 0, then granted.
    push(4'd3, 1'b0, 1'b0);
    idle(8);

    // Three requests with both runways free: 1 -> rw0, 2 -> rw1, 5 stays queued.
    do_reset();
    push(4'd1, 1'b0, 1'b0);
    push(4'd2, 1'b1, 1'b0);
    push(4'd5, 1'b0, 1'b0);
    idle(15);
    check_eq("plan_queue_one", bus.queue_count, 1);
    done(4'd2, 1'b1);
    idle(15);
    // Wrong plane on an owned runway.
    done(4'd9, 1'b0);
    idle(4);

    // Fill the FIFO with both runways held, then keep pushing while a runway is recycled.
    do_reset();
    push(4'd10, 1'b0, 1'b0);
    push(4'd11, 1'b1, 1'b0);
    idle(12);
    for (int i = 0; i < int'(QUEUE_DEPTH) + 2; i++) push(4'(i), 1'(i), 1'b0);
    check_eq("plan_full", bus.queue_count, QUEUE_DEPTH);
    tick(1'b1, 4'd14, 1'b0, 1'b0, 1'b1, 4'd10, 1'b0);
    for (int i = 0; i < 12; i++) push(4'd15, 1'b1, 1'b0);

    // Emergency request behind three queued requests.
    do_reset();
    push(4'd10, 1'b0, 1'b0);
    push(4'd11, 1'b0, 1'b0);
    idle(12);
    push(4'd12, 1'b0, 1'b0);
    push(4'd13, 1'b1, 1'b0);
    push(4'd14, 1'b0, 1'b0);
    push(4'd7, 1'b1, 1'b1);
    push(4'd8, 1'b1, 1'b1);
    done(4'd10, 1'b0);
    idle(15);

    // Randomized traffic with a reset in the middle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      rv = ($urandom_range(0, 1) == 1);
      rp = 4'($urandom_range(0, 15));
      rt = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 5) == 0);
      dv = ($urandom_range(0, 7) == 0);
      dr = 1'($urandom_range(0, 1));
      dp = ($urandom_range(0, 3) != 0 && m_owned[dr]) ? m_owner[dr] : 4'($urandom_range(0, 15));
      tick(rv, rp, rt, re, dv, dp, dr);
    end

    // Drain: no new requests, owners release their runways.
    for (int c = 0; c < 500; c++) begin
      dr = 1'($urandom_range(0, 1));
      dv = ($urandom_range(0, 3) == 0) && m_owned[dr];
      tick(1'b0, 4'd0, 1'b0, 1'b0, dv, m_owner[dr], dr);
    end
    check_eq("drain_empty", bus.queue_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
